// File: rtl/niosii_system_sysid_checker_pkg.sv
// Shared definitions for the sysid checker: FSM states, CPU register map and STATUS layout.
package niosii_system_sysid_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_WAIT_ID,
    ST_RD_TS,
    ST_WAIT_TS,
    ST_COMPARE
  } state_e;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CAP_ID  = 2'd1;
  localparam logic [1:0] REG_CAP_TS  = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  localparam logic [7:0] MISMATCH_MAX = 8'hFF;

  function automatic logic [31:0] packStatus(input logic [7:0] mismatchCnt,
                                             input logic timeout,
                                             input logic busy,
                                             input logic idError,
                                             input logic idOk);
    return {16'b0, mismatchCnt, 4'b0, timeout, busy, idError, idOk};
  endfunction

endpackage

// File: rtl/niosii_system_sysid_checker_master_rd.sv
// Single Avalon-MM read engine: holds the read while stalled, counts stall cycles toward a timeout
// and tracks fixed read latency so the owner knows which cycle carries valid readdata.
module niosii_system_sysid_checker_master_rd #(
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_i,
  input  logic        wait_i,
  input  logic        addr_i,
  input  logic        waitrequest_i,
  input  logic [31:0] readdata_i,
  output logic        sysid_read_o,
  output logic        sysid_address_o,
  output logic        accept_o,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic        timeout_o
);

  localparam int              STALL_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]      LAT_LOAD   = 2'(READ_LATENCY);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic [1:0]         lat_q, lat_d;

  assign sysid_read_o    = req_i;
  assign sysid_address_o = addr_i;
  assign accept_o        = req_i && !waitrequest_i;
  assign timeout_o       = req_i && waitrequest_i && (stall_q == STALL_LAST);
  assign data_o          = readdata_i;

  // Zero latency means data rides with the accept; otherwise it lands the cycle the count expires.
  assign valid_o = (READ_LATENCY == 0) ? accept_o : (wait_i && (lat_q == 2'd1));

  always_comb begin
    stall_d = stall_q;
    lat_d   = lat_q;
    if (!req_i || !waitrequest_i) begin
      stall_d = '0;
    end else begin
      stall_d = stall_q + 1'b1;
    end
    if (accept_o) begin
      lat_d = LAT_LOAD;
    end else if (wait_i && (lat_q != 2'd0)) begin
      lat_d = lat_q - 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      lat_q   <= '0;
    end else begin
      stall_q <= stall_d;
      lat_q   <= lat_d;
    end
  end

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Reads the sysid ID and timestamp words, compares them with build-time values and exposes
// sticky pass/fail flags plus a small CPU register file for boot firmware to poll.
module niosii_system_sysid_checker
  import niosii_system_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1486166856,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned RECHECK_CYCLES = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic        sysid_waitrequest,
  input  logic [31:0] sysid_readdata,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        id_ok,
  output logic        id_error
);

  localparam logic [31:0] RECHECK_LAST =
    (RECHECK_CYCLES == 0) ? 32'd0 : 32'(RECHECK_CYCLES - 1);

  state_e      state_q, state_d;
  logic        first_q;
  logic [31:0] capId_q, capId_d;
  logic [31:0] capTs_q, capTs_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  mism_q, mism_d;
  logic [31:0] recheck_q, recheck_d;
  logic [31:0] rd_q;
  logic [31:0] rdMux;

  logic        rdReq, rdWait, rdAddr;
  logic        rdAccept, rdValid, rdTimeout;
  logic [31:0] rdData;
  logic        busy, pass, go, recheckFire;
  logic        startWr, clearWr;
  logic        unusedWriteBits;

  assign startWr = avs_write && (avs_address == REG_CONTROL) && avs_writedata[CTRL_START_BIT];
  assign clearWr = avs_write && (avs_address == REG_CONTROL) && avs_writedata[CTRL_CLEAR_BIT];
  assign unusedWriteBits = ^avs_writedata[31:2];
  assign busy    = (state_q != ST_IDLE);
  assign go      = first_q || startWr || recheckFire;

  niosii_system_sysid_checker_master_rd #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rd (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_i          (rdReq),
    .wait_i         (rdWait),
    .addr_i         (rdAddr),
    .waitrequest_i  (sysid_waitrequest),
    .readdata_i     (sysid_readdata),
    .sysid_read_o   (sysid_read),
    .sysid_address_o(sysid_address),
    .accept_o       (rdAccept),
    .valid_o        (rdValid),
    .data_o         (rdData),
    .timeout_o      (rdTimeout)
  );

  // The timer only runs while idle, so every return to IDLE restarts the period from zero.
  always_comb begin
    recheck_d   = recheck_q;
    recheckFire = 1'b0;
    if (state_q != ST_IDLE) begin
      recheck_d = '0;
    end else if (RECHECK_CYCLES != 0) begin
      if (recheck_q == RECHECK_LAST) begin
        recheckFire = 1'b1;
      end else begin
        recheck_d = recheck_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rdReq     = 1'b0;
    rdWait    = 1'b0;
    rdAddr    = 1'b0;
    capId_d   = capId_q;
    capTs_d   = capTs_q;
    ok_d      = ok_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    mism_d    = mism_q;
    pass      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_RD_ID;
      end
      ST_RD_ID: begin
        rdReq = 1'b1;
        if (rdTimeout) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          err_d     = 1'b1;
          ok_d      = 1'b0;
        end else if (rdAccept) begin
          state_d = (READ_LATENCY == 0) ? ST_RD_TS : ST_WAIT_ID;
        end
        if (rdValid) capId_d = rdData;
      end
      ST_WAIT_ID: begin
        rdWait = 1'b1;
        if (rdValid) begin
          capId_d = rdData;
          state_d = ST_RD_TS;
        end
      end
      ST_RD_TS: begin
        rdReq  = 1'b1;
        rdAddr = 1'b1;
        if (rdTimeout) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          err_d     = 1'b1;
          ok_d      = 1'b0;
        end else if (rdAccept) begin
          state_d = (READ_LATENCY == 0) ? ST_COMPARE : ST_WAIT_TS;
        end
        if (rdValid) capTs_d = rdData;
      end
      ST_WAIT_TS: begin
        rdWait = 1'b1;
        rdAddr = 1'b1;
        if (rdValid) begin
          capTs_d = rdData;
          state_d = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        pass      = (capId_q == EXPECTED_ID) && (capTs_q == EXPECTED_TS);
        ok_d      = pass;
        err_d     = !pass;
        timeout_d = 1'b0;
        if (!pass && (mism_q != MISMATCH_MAX)) mism_d = mism_q + 8'd1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A clear landing on a failing compare must leave the counter at zero.
    if (clearWr) mism_d = '0;
  end

  always_comb begin
    rdMux = 32'd0;
    case (avs_address)
      REG_STATUS: rdMux = packStatus(mism_q, timeout_q, busy, err_q, ok_q);
      REG_CAP_ID: rdMux = capId_q;
      REG_CAP_TS: rdMux = capTs_q;
      default:    rdMux = 32'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      first_q   <= 1'b1;
      capId_q   <= '0;
      capTs_q   <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      mism_q    <= '0;
      recheck_q <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      first_q   <= 1'b0;
      capId_q   <= capId_d;
      capTs_q   <= capTs_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      mism_q    <= mism_d;
      recheck_q <= recheck_d;
      if (avs_read) rd_q <= rdMux;
    end
  end

  assign avs_readdata = rd_q;
  assign id_ok        = ok_q;
  assign id_error     = err_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Drives two checkers (zero and two-cycle read latency) against a sysid slave model and
// compares every register and flag with an abstract model of what each check should report.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1486166856;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        waitrequest = 1'b0;
  logic [1:0]  avsAddress = 2'd0;
  logic        avsRead = 1'b0;
  logic        avsWrite = 1'b0;
  logic [31:0] avsWritedata = 32'd0;
  logic [31:0] memId = EXP_ID;
  logic [31:0] memTs = EXP_TS;

  logic        sysAddrA, sysReadA, okA, errA;
  logic        sysAddrB, sysReadB, okB, errB;
  logic [31:0] rdataA, rdataB, avsRdA, avsRdB;

  logic        s1v, s2v, s1a, s2a;
  int          idAccA = 0, idAccB = 0, stallA = 0, stallB = 0;

  int          checks = 0;
  int          errors = 0;
  int          modelMism = 0;
  logic        modelOk = 1'b0, modelErr = 1'b0, modelTimeout = 1'b0;
  logic [31:0] modelCapId = 32'd0, modelCapTs = 32'd0;

  always #5 clock = ~clock;

  niosii_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(0),
    .TIMEOUT_CYCLES(255), .RECHECK_CYCLES(0)
  ) dutA (
    .clock(clock), .reset_n(reset_n),
    .sysid_address(sysAddrA), .sysid_read(sysReadA),
    .sysid_waitrequest(waitrequest), .sysid_readdata(rdataA),
    .avs_address(avsAddress), .avs_read(avsRead), .avs_write(avsWrite),
    .avs_writedata(avsWritedata), .avs_readdata(avsRdA),
    .id_ok(okA), .id_error(errA)
  );

  niosii_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(2),
    .TIMEOUT_CYCLES(255), .RECHECK_CYCLES(0)
  ) dutB (
    .clock(clock), .reset_n(reset_n),
    .sysid_address(sysAddrB), .sysid_read(sysReadB),
    .sysid_waitrequest(waitrequest), .sysid_readdata(rdataB),
    .avs_address(avsAddress), .avs_read(avsRead), .avs_write(avsWrite),
    .avs_writedata(avsWritedata), .avs_readdata(avsRdB),
    .id_ok(okB), .id_error(errB)
  );

  // Zero-latency slave answers combinationally; the latency-2 slave shows garbage until data is due.
  assign rdataA = sysAddrA ? memTs : memId;
  assign rdataB = s2v ? (s2a ? memTs : memId) : 32'hDEAD_BEEF;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1v <= 1'b0; s1a <= 1'b0; s2v <= 1'b0; s2a <= 1'b0;
    end else begin
      s1v <= sysReadB && !waitrequest;
      s1a <= sysAddrB;
      s2v <= s1v;
      s2a <= s1a;
    end
  end

  always @(posedge clock) begin
    if (sysReadA && !waitrequest && !sysAddrA) idAccA <= idAccA + 1;
    if (sysReadB && !waitrequest && !sysAddrB) idAccB <= idAccB + 1;
    if (sysReadA && waitrequest) stallA <= stallA + 1;
    if (sysReadB && waitrequest) stallB <= stallB + 1;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic writeCtrl(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clock);
    avsAddress = addr; avsWrite = 1'b1; avsWritedata = data;
    @(negedge clock);
    avsWrite = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [31:0] ra, output logic [31:0] rb);
    @(negedge clock);
    avsAddress = addr; avsRead = 1'b1;
    @(negedge clock);
    avsRead = 1'b0;
    ra = avsRdA; rb = avsRdB;
  endtask

  task automatic applyStimulus(input logic [31:0] idWord, input logic [31:0] tsWord);
    memId = idWord;
    memTs = tsWord;
    writeCtrl(2'd3, 32'h1);
  endtask

  task automatic waitIdle();
    logic [31:0] a, b;
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      readReg(2'd0, a, b);
      if (!a[2] && !b[2]) done = 1'b1;
    end
    checkOutput("idleReached", {31'b0, done}, 32'd1);
  endtask

  function automatic logic [31:0] modelStatus();
    int v;
    v = modelMism * 256 + (modelTimeout ? 8 : 0) + (modelErr ? 2 : 0) + (modelOk ? 1 : 0);
    return 32'(v);
  endfunction

  task automatic modelCheck();
    bit pass;
    pass = (memId == EXP_ID) && (memTs == EXP_TS);
    modelOk = pass;
    modelErr = !pass;
    modelTimeout = 1'b0;
    if (!pass && modelMism < 255) modelMism++;
    modelCapId = memId;
    modelCapTs = memTs;
  endtask

  task automatic verifyAll();
    logic [31:0] a, b;
    readReg(2'd0, a, b);
    checkOutput("statusA", a, modelStatus());
    checkOutput("statusB", b, modelStatus());
    readReg(2'd1, a, b);
    checkOutput("capIdA", a, modelCapId);
    checkOutput("capIdB", b, modelCapId);
    readReg(2'd2, a, b);
    checkOutput("capTsA", a, modelCapTs);
    checkOutput("capTsB", b, modelCapTs);
    readReg(2'd3, a, b);
    checkOutput("controlReadsZeroA", a, 32'd0);
    checkOutput("okPinA", {31'b0, okA}, {31'b0, modelOk});
    checkOutput("errPinA", {31'b0, errA}, {31'b0, modelErr});
    checkOutput("okPinB", {31'b0, okB}, {31'b0, modelOk});
    checkOutput("errPinB", {31'b0, errB}, {31'b0, modelErr});
  endtask

  initial begin
    logic [31:0] a, b, id, ts;
    int cyc, accA0, accB0, stA0, stB0;

    // Reset state and the automatic boot check.
    repeat (3) @(negedge clock);
    checkOutput("resetOkA", {31'b0, okA}, 32'd0);
    checkOutput("resetReadA", {31'b0, sysReadA}, 32'd0);
    reset_n = 1'b1;
    cyc = 0;
    while (!okA && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput("bootLatencyA", 32'(cyc <= 6), 32'd1);
    waitIdle();
    modelCheck();
    verifyAll();
    readReg(2'd0, a, b);
    checkOutput("bootStatusA", a, 32'h0000_0001);

    // Timestamp off by one.
    applyStimulus(EXP_ID, EXP_TS + 32'd1);
    waitIdle();
    modelCheck();
    verifyAll();
    readReg(2'd0, a, b);
    checkOutput("tsFailStatusA", a, 32'h0000_0102);

    // Randomized ID/TS words, each half the time correct.
    for (int i = 0; i < 12; i++) begin
      id = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom();
      ts = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom();
      applyStimulus(id, ts);
      waitIdle();
      modelCheck();
      verifyAll();
    end

    // A second start while busy must not launch another check.
    accA0 = idAccA; accB0 = idAccB;
    applyStimulus(32'h1234_5678, EXP_TS);
    writeCtrl(2'd3, 32'h1);
    waitIdle();
    modelCheck();
    verifyAll();
    checkOutput("oneCheckA", 32'(idAccA - accA0), 32'd1);
    checkOutput("oneCheckB", 32'(idAccB - accB0), 32'd1);

    // Slave stalls forever: read must be dropped after 255 stalled cycles.
    stA0 = stallA; stB0 = stallB;
    waitrequest = 1'b1;
    writeCtrl(2'd3, 32'h1);
    waitIdle();
    waitrequest = 1'b0;
    modelOk = 1'b0; modelErr = 1'b1; modelTimeout = 1'b1;
    checkOutput("stallCyclesA", 32'(stallA - stA0), 32'd255);
    checkOutput("stallCyclesB", 32'(stallB - stB0), 32'd255);
    checkOutput("readDroppedA", {31'b0, sysReadA}, 32'd0);
    verifyAll();

    // Drive the mismatch counter into saturation.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(EXP_ID, EXP_TS ^ 32'h8000_0000);
      waitIdle();
      modelCheck();
    end
    verifyAll();
    checkOutput("saturated", 32'(modelMism), 32'd255);

    // Clear lands exactly on dutA's failing compare; dutB is still reading then.
    applyStimulus(32'hFFFF_FFFF, EXP_TS);
    @(negedge clock);
    writeCtrl(2'd3, 32'h2);
    waitIdle();
    modelCheck();
    readReg(2'd0, a, b);
    checkOutput("clearWinsA", a, 32'h0000_0002);
    checkOutput("clearThenFailB", b, 32'h0000_0102);

    writeCtrl(2'd3, 32'h2);
    applyStimulus(EXP_ID, EXP_TS);
    waitIdle();
    modelMism = 0;
    modelCheck();
    verifyAll();

    // Reset while dutB sits in its timestamp wait.
    readReg(2'd2, a, b);
    applyStimulus(EXP_ID, EXP_TS);
    repeat (4) @(negedge clock);
    checkOutput("inWaitTsAddrB", {31'b0, sysAddrB}, 32'd1);
    checkOutput("inWaitTsReadB", {31'b0, sysReadB}, 32'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("rstReadB", {31'b0, sysReadB}, 32'd0);
    checkOutput("rstAddrB", {31'b0, sysAddrB}, 32'd0);
    checkOutput("rstAvsRdA", avsRdA, 32'd0);
    checkOutput("rstAvsRdB", avsRdB, 32'd0);
    checkOutput("rstOkA", {31'b0, okA}, 32'd0);
    checkOutput("rstErrB", {31'b0, errB}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    modelMism = 0; modelOk = 1'b0; modelErr = 1'b0; modelTimeout = 1'b0;
    modelCapId = 32'd0; modelCapTs = 32'd0;
    waitIdle();
    modelCheck();
    verifyAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
